// File: rtl/chip_7400_emulator.sv
// ---------------------------------------------------------------------------
// chip_7400_emulator
//
// Behavioural stand-in for a 7400 quad 2-input NAND on the tester pin bus.
// Each gate computes Y = ~(first & second). One gate can be given a
// triggered, optionally time-limited fault (stuck-at-0, stuck-at-1 or
// inverted). The fault is applied at the input of a DELAY-stage output
// pipeline, so the fault appears and clears with the same latency as a
// normal pin change.
//
// Optional feature macro: CHIP_EMU_VECCNT_EN
//   defined   -> input-vector register and saturating Vec_Count are built
//   undefined -> Vec_Count is tied to 0
//
// Ports:
//   Clk, Reset           clock, asynchronous active-low reset
//   Pin1/2 -> Pin3       gate A      Pin4/5   -> Pin6   gate B
//   Pin9/10 -> Pin8      gate C      Pin12/13 -> Pin11  gate D
//   Fault_Load/Clear     single-cycle strobes (Clear wins)
//   Fault_Gate/Mode/Trig/Hold  fault configuration captured on Fault_Load
//   Fault_Active, Armed  FSM state indicators
//   Vec_Count            saturating count of input-vector changes
// ---------------------------------------------------------------------------
module chip_7400_emulator #(
    parameter int DELAY  = 1,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Pin1,
    input  logic              Pin2,
    output logic              Pin3,
    input  logic              Pin4,
    input  logic              Pin5,
    output logic              Pin6,
    input  logic              Pin9,
    input  logic              Pin10,
    output logic              Pin8,
    input  logic              Pin12,
    input  logic              Pin13,
    output logic              Pin11,
    input  logic              Fault_Load,
    input  logic              Fault_Clear,
    input  logic [1:0]        Fault_Gate,
    input  logic [1:0]        Fault_Mode,
    input  logic [1:0]        Fault_Trig,
    input  logic [HOLD_W-1:0] Fault_Hold,
    output logic              Fault_Active,
    output logic              Armed,
    output logic [CNT_W-1:0]  Vec_Count
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_ARMED   = 2'b01,
        ST_FAULTED = 2'b10
    } state_e;

    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    // Fault transform for one gate output.
    function automatic logic apply_fault(input logic y, input logic [1:0] mode);
        logic r;
        case (mode)
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            2'b11:   r = ~y;
            default: r = y;
        endcase
        return r;
    endfunction

    // Packed pins: bit 2g is the first input of gate g, bit 2g+1 the second.
    logic [7:0] pins_s;
    logic [3:0] y_s;
    logic [3:0] line_in_s;
    logic [3:0] out_s;
    logic [1:0] pair_s;

    state_e            state_q, state_d;
    logic [1:0]        gate_q, gate_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        trig_q, trig_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    assign pins_s = {Pin13, Pin12, Pin10, Pin9, Pin5, Pin4, Pin2, Pin1};

    // Plain NAND of each gate's input pair.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            y_s[g] = ~(pins_s[2*g] & pins_s[2*g+1]);
        end
    end

    // Input pair of the captured target gate, {first, second}.
    always_comb begin
        case (gate_q)
            2'd0:    pair_s = {pins_s[0], pins_s[1]};
            2'd1:    pair_s = {pins_s[2], pins_s[3]};
            2'd2:    pair_s = {pins_s[4], pins_s[5]};
            2'd3:    pair_s = {pins_s[6], pins_s[7]};
            default: pair_s = 2'b00;
        endcase
    end

    // Fault transform is only live in FAULTED; applied ahead of the pipeline.
    always_comb begin
        line_in_s = y_s;
        if (state_q == ST_FAULTED) begin
            line_in_s[gate_q] = apply_fault(y_s[gate_q], mode_q);
        end else begin
            line_in_s = y_s;
        end
    end

    // FSM next state, configuration capture and hold countdown.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        mode_d  = mode_q;
        trig_d  = trig_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (Fault_Clear) begin
            state_d = ST_NORMAL;
            cnt_d   = HOLD_ZERO;
        end else if (Fault_Load) begin
            // A trigger match on the load edge is deliberately ignored.
            gate_d  = Fault_Gate;
            mode_d  = Fault_Mode;
            trig_d  = Fault_Trig;
            hold_d  = Fault_Hold;
            cnt_d   = HOLD_ZERO;
            state_d = (Fault_Mode != 2'b00) ? ST_ARMED : ST_NORMAL;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    state_d = ST_NORMAL;
                end
                ST_ARMED: begin
                    if (pair_s == trig_q) begin
                        state_d = ST_FAULTED;
                        cnt_d   = hold_q;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_FAULTED: begin
                    // Counter holds the cycles left including the current one.
                    if (hold_q == HOLD_ZERO) begin
                        state_d = ST_FAULTED;
                    end else if (cnt_q == HOLD_ONE) begin
                        state_d = ST_NORMAL;
                        cnt_d   = HOLD_ZERO;
                    end else begin
                        cnt_d = cnt_q - HOLD_ONE;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    cnt_d   = HOLD_ZERO;
                end
            endcase
        end
    end

    // FSM and configuration registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_NORMAL;
            gate_q  <= 2'b00;
            mode_q  <= 2'b00;
            trig_q  <= 2'b00;
            hold_q  <= HOLD_ZERO;
            cnt_q   <= HOLD_ZERO;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            mode_q  <= mode_d;
            trig_q  <= trig_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Fault_Active = (state_q == ST_FAULTED);
    assign Armed        = (state_q == ST_ARMED);

    generate
        if (DELAY == 0) begin : g_comb
            assign out_s = line_in_s;
        end else begin : g_pipe
            logic [3:0] pipe_q [DELAY];

            // Output shift pipeline; resets to the NAND of idle 0,0 inputs.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < DELAY; i++) begin
                        pipe_q[i] <= 4'hF;
                    end
                end else begin
                    pipe_q[0] <= line_in_s;
                    for (int i = 1; i < DELAY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign out_s = pipe_q[DELAY-1];
        end
    endgenerate

    assign Pin3  = out_s[0];
    assign Pin6  = out_s[1];
    assign Pin8  = out_s[2];
    assign Pin11 = out_s[3];

`ifdef CHIP_EMU_VECCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [7:0]       vec_q;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    // Count when the freshly registered vector differs from the held one.
    always_comb begin
        vcnt_d = vcnt_q;
        if ((pins_s != vec_q) && (vcnt_q != CNT_MAX)) begin
            vcnt_d = vcnt_q + CNT_ONE;
        end else begin
            vcnt_d = vcnt_q;
        end
    end

    // Vector register and change counter; Fault_Clear does not touch them.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vec_q  <= 8'h00;
            vcnt_q <= {CNT_W{1'b0}};
        end else begin
            vec_q  <= pins_s;
            vcnt_q <= vcnt_d;
        end
    end

    assign Vec_Count = vcnt_q;
`else
    assign Vec_Count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_chip_7400_emulator.sv
// ---------------------------------------------------------------------------
// tb_chip_7400_emulator
//
// Drives two emulators from the same pins: u_dut (defaults, DELAY=1) and
// u_dut0 (DELAY=0, CNT_W=2). A behavioural reference model tracks the fault
// state and the expected pin values; directed sequences and a random phase
// are compared against it every cycle.
// ---------------------------------------------------------------------------
module tb_chip_7400_emulator;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] pv = 8'h00;   // {Pin13,Pin12,Pin10,Pin9,Pin5,Pin4,Pin2,Pin1}
    logic       Fault_Load = 1'b0;
    logic       Fault_Clear = 1'b0;
    logic [1:0] Fault_Gate = 2'b00;
    logic [1:0] Fault_Mode = 2'b00;
    logic [1:0] Fault_Trig = 2'b00;
    logic [7:0] Fault_Hold = 8'h00;

    logic Pin3, Pin6, Pin8, Pin11, Fault_Active, Armed;
    logic [7:0] Vec_Count;
    logic d0_pin3, d0_pin6, d0_pin8, d0_pin11, d0_active, d0_armed;
    logic [1:0] d0_vec;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    chip_7400_emulator #(.DELAY(1), .HOLD_W(8), .CNT_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .Pin1(pv[0]), .Pin2(pv[1]), .Pin3(Pin3),
        .Pin4(pv[2]), .Pin5(pv[3]), .Pin6(Pin6),
        .Pin9(pv[4]), .Pin10(pv[5]), .Pin8(Pin8),
        .Pin12(pv[6]), .Pin13(pv[7]), .Pin11(Pin11),
        .Fault_Load(Fault_Load), .Fault_Clear(Fault_Clear),
        .Fault_Gate(Fault_Gate), .Fault_Mode(Fault_Mode),
        .Fault_Trig(Fault_Trig), .Fault_Hold(Fault_Hold),
        .Fault_Active(Fault_Active), .Armed(Armed), .Vec_Count(Vec_Count)
    );

    chip_7400_emulator #(.DELAY(0), .HOLD_W(8), .CNT_W(2)) u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .Pin1(pv[0]), .Pin2(pv[1]), .Pin3(d0_pin3),
        .Pin4(pv[2]), .Pin5(pv[3]), .Pin6(d0_pin6),
        .Pin9(pv[4]), .Pin10(pv[5]), .Pin8(d0_pin8),
        .Pin12(pv[6]), .Pin13(pv[7]), .Pin11(d0_pin11),
        .Fault_Load(Fault_Load), .Fault_Clear(Fault_Clear),
        .Fault_Gate(Fault_Gate), .Fault_Mode(Fault_Mode),
        .Fault_Trig(Fault_Trig), .Fault_Hold(Fault_Hold),
        .Fault_Active(d0_active), .Armed(d0_armed), .Vec_Count(d0_vec)
    );

    // ---------------- reference model ----------------
    int         m_state = 0;      // 0 normal, 1 armed, 2 faulted
    int         m_gate = 0;
    int         m_mode = 0;
    int         m_trig = 0;
    int         m_hold = 0;
    int         m_left = 0;       // faulted cycles remaining (when m_hold != 0)
    logic [3:0] m_out1 = 4'hF;    // what the DELAY=1 outputs should show
    logic [7:0] m_last = 8'h00;
    int         m_vc8 = 0;
    int         m_vc2 = 0;

    // Expected gate outputs {D,C,B,A} for pins p with the current fault state.
    function automatic logic [3:0] ideal(input logic [7:0] p);
        logic [3:0] r;
        for (int g = 0; g < 4; g++) begin
            r[g] = !(p[2*g] && p[2*g+1]);
            if (m_state == 2 && g == m_gate) begin
                if (m_mode == 1) r[g] = 1'b0;
                else if (m_mode == 2) r[g] = 1'b1;
                else if (m_mode == 3) r[g] = !r[g];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_gate = 0; m_mode = 0; m_trig = 0; m_hold = 0; m_left = 0;
        m_out1 = 4'hF; m_last = 8'h00; m_vc8 = 0; m_vc2 = 0;
    endtask

    // One clock edge of the model, using the inputs present before the edge.
    task automatic model_edge();
        int pair;
        m_out1 = ideal(pv);
        if (pv != m_last) begin
            if (m_vc8 < 255) m_vc8++;
            if (m_vc2 < 3) m_vc2++;
        end
        m_last = pv;
        pair = {pv[2*m_gate], pv[2*m_gate+1]};
        if (Fault_Clear) begin
            m_state = 0;
        end else if (Fault_Load) begin
            m_gate = Fault_Gate; m_mode = Fault_Mode;
            m_trig = Fault_Trig; m_hold = Fault_Hold;
            m_state = (Fault_Mode != 0) ? 1 : 0;
        end else if (m_state == 1) begin
            if (pair == m_trig) begin
                m_state = 2;
                m_left = m_hold;
            end
        end else if (m_state == 2 && m_hold != 0) begin
            m_left--;
            if (m_left == 0) m_state = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("dly1_pins", {28'd0, Pin11, Pin8, Pin6, Pin3}, {28'd0, m_out1});
        chk("dly0_pins", {28'd0, d0_pin11, d0_pin8, d0_pin6, d0_pin3}, {28'd0, ideal(pv)});
        chk("fault_active", {31'd0, Fault_Active}, {31'd0, (m_state == 2)});
        chk("armed", {31'd0, Armed}, {31'd0, (m_state == 1)});
        chk("dly0_state", {30'd0, d0_active, d0_armed}, {30'd0, (m_state == 2), (m_state == 1)});
`ifdef CHIP_EMU_VECCNT_EN
        chk("vec_count8", {24'd0, Vec_Count}, m_vc8);
        chk("vec_count2", {30'd0, d0_vec}, m_vc2);
`else
        chk("vec_count8", {24'd0, Vec_Count}, 32'd0);
        chk("vec_count2", {30'd0, d0_vec}, 32'd0);
`endif
    endtask

    // Apply one cycle of stimulus (called at a negedge), step model, check.
    task automatic step(input logic [7:0] p, input logic ld, input logic clr,
                        input logic [1:0] g, input logic [1:0] m,
                        input logic [1:0] t, input logic [7:0] h);
        pv = p; Fault_Load = ld; Fault_Clear = clr;
        Fault_Gate = g; Fault_Mode = m; Fault_Trig = t; Fault_Hold = h;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        Fault_Load = 1'b0; Fault_Clear = 1'b0;
        check_all();
    endtask

    task automatic idle(input logic [7:0] p);
        step(p, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    endtask

    // Asynchronous reset pulse; outputs must take reset values at once.
    task automatic do_reset();
        Reset = 1'b0;
        #1;
        chk("reset_pins", {28'd0, Pin11, Pin8, Pin6, Pin3}, 32'hF);
        chk("reset_state", {28'd0, Fault_Active, Armed, d0_active, d0_armed}, 32'd0);
        chk("reset_vec", {22'd0, Vec_Count, d0_vec}, 32'd0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        pv = 8'h00;
        Reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0] ab;   // {Pin1, Pin2}
        logic       y;    // expected Pin3
    } vec_t;

    initial begin
        vec_t tbl [4];
        int   n_act;
        int   n_low;
        int   exp_vc [5];
        logic [7:0] rp;

        tbl[0] = '{2'b00, 1'b1};
        tbl[1] = '{2'b01, 1'b1};
        tbl[2] = '{2'b10, 1'b1};
        tbl[3] = '{2'b11, 1'b0};
        exp_vc[0] = 1; exp_vc[1] = 2; exp_vc[2] = 3; exp_vc[3] = 3; exp_vc[4] = 3;

        @(negedge Clk);
        do_reset();

        // Gate A truth table, one cycle per vector.
        for (int i = 0; i < 4; i++) begin
            rp = {6'b000000, tbl[i].ab[0], tbl[i].ab[1]};
            idle(rp);
            chk("tbl_pin3", {31'd0, Pin3}, {31'd0, tbl[i].y});
            chk("tbl_others", {29'd0, Pin11, Pin8, Pin6}, 32'd7);
        end
        idle(8'h00);

        // Stuck-at-1 on gate D, trigger 11, permanent, then clear.
        step(8'hC0, 1'b1, 1'b0, 2'd3, 2'b10, 2'b11, 8'd0);
        chk("seq2_armed", {31'd0, Armed}, 32'd1);
        idle(8'hC0);
        chk("seq2_active", {31'd0, Fault_Active}, 32'd1);
        idle(8'hC0);
        chk("seq2_pin11_forced", {31'd0, Pin11}, 32'd1);
        step(8'hC0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'd0);
        chk("seq2_pin11_lag", {31'd0, Pin11}, 32'd1);
        idle(8'hC0);
        chk("seq2_pin11_clear", {31'd0, Pin11}, 32'd0);
        idle(8'h00);

        // Inverted fault on gate A, trigger 00, hold 3.
        step(8'h00, 1'b1, 1'b0, 2'd0, 2'b11, 2'b00, 8'd3);
        n_act = 0; n_low = 0;
        for (int i = 0; i < 7; i++) begin
            idle(8'h00);
            if (Fault_Active) n_act++;
            if (!Pin3) n_low++;
        end
        chk("seq3_active_cycles", n_act, 32'd3);
        chk("seq3_pin3_low_cycles", n_low, 32'd3);

        // Load and Clear together: never leaves NORMAL.
        step(8'h00, 1'b1, 1'b1, 2'd1, 2'b01, 2'b00, 8'd0);
        n_act = 0;
        for (int i = 0; i < 3; i++) begin
            idle(8'h00);
            if (Armed || Fault_Active) n_act++;
        end
        chk("seq4_no_arm", n_act, 32'd0);

        // Reset during a stuck-at-1 fault on gate B.
        step(8'h0C, 1'b1, 1'b0, 2'd1, 2'b10, 2'b11, 8'd0);
        idle(8'h0C);
        idle(8'h0C);
        chk("seq5_pin6_faulted", {31'd0, Pin6}, 32'd1);
        do_reset();
        idle(8'h0C);
        chk("seq5_pin6_after", {31'd0, Pin6}, 32'd0);
        chk("seq5_no_fault", {31'd0, Fault_Active}, 32'd0);

        // Vector counter saturation on the CNT_W=2 instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle({7'd0, (i % 2 == 0)});
`ifdef CHIP_EMU_VECCNT_EN
            chk("seq6_vec2", {30'd0, d0_vec}, exp_vc[i]);
`else
            chk("seq6_vec2", {30'd0, d0_vec}, 32'd0);
`endif
        end

        // Random phase against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0),
                 2'($urandom), 2'($urandom), 2'($urandom),
                 8'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
